// File: rtl/axis_sample_unpacker_pkg.sv
// Shared definitions for the packed-sample unpacker: FSM encoding, default
// sample width and the sign-extension helper.
package axis_sample_unpacker_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } state_t;

    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int EXT_MAX          = 64;

    // Sign-extends the low w bits of s to EXT_MAX bits; callers slice to their width.
    function automatic logic [EXT_MAX-1:0] sign_extend(input logic [EXT_MAX-1:0] s, input int w);
        logic signed [EXT_MAX-1:0] t;
        t = $signed(s << (EXT_MAX - w));
        return t >>> (EXT_MAX - w);
    endfunction

endpackage

// File: rtl/axis_sample_unpacker.sv
// Splits 32-bit AXIS words into two sign-extended samples, trims a programmable
// number of leading samples per frame and keeps per-frame statistics.
module axis_sample_unpacker
    import axis_sample_unpacker_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH    = SAMPLE_WIDTH_DEF,
    parameter int OUT_WIDTH       = 32,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       AXIS_clk,
    input  logic                       AXIS_rst,
    input  logic                       SRC_AXIS_tvalid,
    output logic                       SRC_AXIS_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] SRC_AXIS_tdata,
    input  logic                       SRC_AXIS_tlast,
    input  logic                       SRC_AXIS_tuser,
    output logic                       SINK_AXIS_tvalid,
    input  logic                       SINK_AXIS_tready,
    output logic [OUT_WIDTH-1:0]       SINK_AXIS_tdata,
    output logic                       SINK_AXIS_tlast,
    output logic                       SINK_AXIS_tuser,
    input  logic [CNT_WIDTH-1:0]       i_skip_len,
    output logic [CNT_WIDTH-1:0]       o_frame_count,
    output logic [CNT_WIDTH-1:0]       o_last_frame_len,
    output logic                       o_busy
);

    state_t                     state, nxt_state;
    logic [AXIS_DATA_WIDTH-1:0] word, nxt_word;
    logic                       hold_last, nxt_hold_last;
    logic [CNT_WIDTH-1:0]       skip_rem, nxt_skip_rem;
    logic [CNT_WIDTH-1:0]       out_cnt, nxt_out_cnt;
    logic [CNT_WIDTH-1:0]       nxt_frame_count, nxt_last_len;
    logic                       in_frame, nxt_in_frame;
    logic                       first_pending, nxt_first_pending;
    logic                       run;
    logic                       accept, handshake, drop, advance;
    logic                       nxt_valid;
    logic [SAMPLE_WIDTH-1:0]    nxt_sample;
    logic [EXT_MAX-1:0]         ext;
    logic                       unused_tuser;

    assign unused_tuser = SRC_AXIS_tuser;

    assign drop      = (state != ST_EMPTY) && (skip_rem != '0);
    assign handshake = SINK_AXIS_tvalid && SINK_AXIS_tready;
    assign advance   = drop || handshake;

    always_comb begin
        SRC_AXIS_tready = 1'b0;
        case (state)
            ST_EMPTY: SRC_AXIS_tready = run;
            ST_HI:    SRC_AXIS_tready = advance;
            default:  SRC_AXIS_tready = 1'b0;
        endcase
    end

    assign accept = SRC_AXIS_tready && SRC_AXIS_tvalid;
    assign o_busy = (state != ST_EMPTY) || in_frame;

    // Next-state and statistics; a frame may end and the next begin in one cycle.
    always_comb begin
        nxt_state         = state;
        nxt_word          = word;
        nxt_hold_last     = hold_last;
        nxt_skip_rem      = skip_rem;
        nxt_out_cnt       = out_cnt;
        nxt_frame_count   = o_frame_count;
        nxt_last_len      = o_last_frame_len;
        nxt_in_frame      = in_frame;
        nxt_first_pending = first_pending;

        if (drop)
            nxt_skip_rem = skip_rem - CNT_WIDTH'(1);
        if (handshake) begin
            if (out_cnt != '1)
                nxt_out_cnt = out_cnt + CNT_WIDTH'(1);
            nxt_first_pending = 1'b0;
        end

        if (state == ST_LO && advance)
            nxt_state = ST_HI;
        if (state == ST_HI && advance) begin
            nxt_state = ST_EMPTY;
            if (hold_last) begin
                nxt_frame_count = o_frame_count + CNT_WIDTH'(1);
                nxt_last_len    = nxt_out_cnt;
                nxt_in_frame    = 1'b0;
            end
        end

        if (accept) begin
            nxt_state     = ST_LO;
            nxt_word      = SRC_AXIS_tdata;
            nxt_hold_last = SRC_AXIS_tlast;
            if (!nxt_in_frame) begin
                nxt_skip_rem      = i_skip_len;
                nxt_in_frame      = 1'b1;
                nxt_out_cnt       = '0;
                nxt_first_pending = 1'b1;
            end
        end
    end

    // Output registers reflect the sample the FSM will hold next cycle.
    assign nxt_valid  = (nxt_state != ST_EMPTY) && (nxt_skip_rem == '0);
    assign nxt_sample = (nxt_state == ST_HI) ? nxt_word[AXIS_DATA_WIDTH-1 -: SAMPLE_WIDTH]
                                             : nxt_word[SAMPLE_WIDTH-1:0];
    assign ext        = sign_extend(EXT_MAX'(nxt_sample), SAMPLE_WIDTH);

    always_ff @(posedge AXIS_clk or negedge AXIS_rst) begin
        if (!AXIS_rst) begin
            state            <= ST_EMPTY;
            hold_last        <= 1'b0;
            skip_rem         <= '0;
            out_cnt          <= '0;
            o_frame_count    <= '0;
            o_last_frame_len <= '0;
            in_frame         <= 1'b0;
            first_pending    <= 1'b0;
            run              <= 1'b0;
            SINK_AXIS_tvalid <= 1'b0;
            SINK_AXIS_tdata  <= '0;
            SINK_AXIS_tlast  <= 1'b0;
            SINK_AXIS_tuser  <= 1'b0;
        end else begin
            state            <= nxt_state;
            hold_last        <= nxt_hold_last;
            skip_rem         <= nxt_skip_rem;
            out_cnt          <= nxt_out_cnt;
            o_frame_count    <= nxt_frame_count;
            o_last_frame_len <= nxt_last_len;
            in_frame         <= nxt_in_frame;
            first_pending    <= nxt_first_pending;
            run              <= 1'b1;
            SINK_AXIS_tvalid <= nxt_valid;
            SINK_AXIS_tdata  <= ext[OUT_WIDTH-1:0];
            SINK_AXIS_tlast  <= nxt_valid && (nxt_state == ST_HI) && nxt_hold_last;
            SINK_AXIS_tuser  <= nxt_valid && nxt_first_pending;
        end
    end

    always_ff @(posedge AXIS_clk) begin
        if (accept)
            word <= SRC_AXIS_tdata;
    end

endmodule

// File: tb/tb_axis_sample_unpacker.sv
// Scoreboard bench for axis_sample_unpacker: directed frames push expected
// beats, an independent monitor pops and compares on every output handshake.
module tb_axis_sample_unpacker;

    typedef struct packed {
        logic        last;
        logic        user;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        src_tvalid = 1'b0;
    logic        src_tready;
    logic [31:0] src_tdata = '0;
    logic        src_tlast = 1'b0;
    logic        src_tuser = 1'b0;
    logic        sink_tvalid;
    logic        sink_tready = 1'b1;
    logic [31:0] sink_tdata;
    logic        sink_tlast;
    logic        sink_tuser;
    logic [31:0] skip = '0;
    logic [31:0] frame_count;
    logic [31:0] last_len;
    logic        busy;

    beat_t q[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    beats_seen = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    int    bp_mode = 0;

    axis_sample_unpacker dut (
        .AXIS_clk         (clk),
        .AXIS_rst         (rst_n),
        .SRC_AXIS_tvalid  (src_tvalid),
        .SRC_AXIS_tready  (src_tready),
        .SRC_AXIS_tdata   (src_tdata),
        .SRC_AXIS_tlast   (src_tlast),
        .SRC_AXIS_tuser   (src_tuser),
        .SINK_AXIS_tvalid (sink_tvalid),
        .SINK_AXIS_tready (sink_tready),
        .SINK_AXIS_tdata  (sink_tdata),
        .SINK_AXIS_tlast  (sink_tlast),
        .SINK_AXIS_tuser  (sink_tuser),
        .i_skip_len       (skip),
        .o_frame_count    (frame_count),
        .o_last_frame_len (last_len),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] sx(input logic [15:0] s);
        return {{16{s[15]}}, s};
    endfunction

    function automatic logic [15:0] smp(input int i);
        return 16'(i * 1237 + 32512);
    endfunction

    task automatic expect_beat(input logic [31:0] d, input logic last, input logic user);
        beat_t b;
        b.last = last;
        b.user = user;
        b.data = d;
        q.push_back(b);
    endtask

    // Sink-ready generator: 0 = always ready, 1 = stalled, 2 = random 50%.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       sink_tready = 1'b1;
                1:       sink_tready = 1'b0;
                default: sink_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare each handshake against the scoreboard, check stall stability.
    initial begin
        beat_t e;
        beat_t held;
        logic  stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stalled)
                    check("stall_hold", 64'({sink_tvalid, sink_tlast, sink_tuser, sink_tdata}),
                          64'({1'b1, held}));
                if (sink_tvalid && sink_tready) begin
                    if (beats_seen == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beats_seen++;
                    if (q.size() == 0) begin
                        check("unexpected_beat", 64'({sink_tlast, sink_tuser, sink_tdata}), 64'(0));
                    end else begin
                        e = q.pop_front();
                        check("beat", 64'({sink_tlast, sink_tuser, sink_tdata}), 64'(e));
                    end
                end
                stalled = sink_tvalid && !sink_tready;
                held = {sink_tlast, sink_tuser, sink_tdata};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic last);
        bit acc;
        int t;
        acc = 1'b0;
        t = 0;
        src_tvalid = 1'b1;
        src_tdata = d;
        src_tlast = last;
        while (!acc && t < 500) begin
            @(negedge clk);
            acc = src_tready;
            if (acc) acc_cyc = cyc;
            @(posedge clk);
            #1;
            t++;
        end
        src_tvalid = 1'b0;
        src_tlast = 1'b0;
        if (!acc) check("src_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((q.size() != 0 || busy || sink_tvalid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("idle", 64'(q.size() == 0 && !busy), 64'(1));
    endtask

    task automatic run_long_frame();
        logic [15:0] a;
        logic [15:0] b;
        int prev;
        prev = 0;
        for (int k = 0; k < 64; k++) begin
            a = smp(2 * k);
            b = smp(2 * k + 1);
            expect_beat(sx(a), 1'b0, 1'(k == 0));
            expect_beat(sx(b), 1'(k == 63), 1'b0);
            send({b, a}, 1'(k == 63));
            if (k > 0 && bp_mode == 0) check("accept_spacing", 64'(acc_cyc - prev), 64'(2));
            prev = acc_cyc;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_src_tready", 64'(src_tready), 64'(0));
        check("rst_outputs", 64'({sink_tvalid, sink_tlast, sink_tuser, sink_tdata}), 64'(0));
        check("rst_counters", 64'({frame_count, last_len}), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word, no skip, sign of high sample negative
        skip = 32'd0;
        expect_beat(32'h0000_0003, 1'b0, 1'b1);
        expect_beat(32'hFFFF_FFFE, 1'b1, 1'b0);
        send(32'hFFFE_0003, 1'b1);
        wait_idle();
        check("f1_count", 64'(frame_count), 64'(1));
        check("f1_len", 64'(last_len), 64'(2));

        // Skip 3 across a 3-word frame
        skip = 32'd3;
        expect_beat(32'd4, 1'b0, 1'b1);
        expect_beat(32'd5, 1'b0, 1'b0);
        expect_beat(32'd6, 1'b1, 1'b0);
        send(32'h0002_0001, 1'b0);
        send(32'h0004_0003, 1'b0);
        send(32'h0006_0005, 1'b1);
        wait_idle();
        check("f2_count", 64'(frame_count), 64'(2));
        check("f2_len", 64'(last_len), 64'(3));

        // Whole frame skipped, then a normal frame at the sign boundary
        skip = 32'd10;
        send(32'h0008_0007, 1'b0);
        send(32'h000A_0009, 1'b1);
        wait_idle();
        check("f3_count", 64'(frame_count), 64'(3));
        check("f3_len", 64'(last_len), 64'(0));
        skip = 32'd0;
        expect_beat(32'h0000_7FFF, 1'b0, 1'b1);
        expect_beat(32'hFFFF_8000, 1'b1, 1'b0);
        send(32'h8000_7FFF, 1'b1);
        wait_idle();
        check("f4_count", 64'(frame_count), 64'(4));
        check("f4_len", 64'(last_len), 64'(2));

        // Continuous 64-word frame, no backpressure
        beats_seen = 0;
        run_long_frame();
        wait_idle();
        check("long_beats", 64'(beats_seen), 64'(128));
        check("long_no_gaps", 64'(last_cyc - first_cyc), 64'(127));
        check("f5_count", 64'(frame_count), 64'(5));
        check("f5_len", 64'(last_len), 64'(128));

        // Same frame under random backpressure
        bp_mode = 2;
        beats_seen = 0;
        run_long_frame();
        wait_idle();
        bp_mode = 0;
        check("bp_beats", 64'(beats_seen), 64'(128));
        check("f6_count", 64'(frame_count), 64'(6));
        check("f6_len", 64'(last_len), 64'(128));

        // Asynchronous reset while a sample is held under stall
        bp_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        skip = 32'd1;
        send(32'h1111_2222, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("held_before_rst", 64'({sink_tvalid, sink_tdata}), 64'({1'b1, 32'h0000_1111}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 64'({sink_tvalid, sink_tlast, sink_tuser, sink_tdata}), 64'(0));
        check("async_rst_ready_busy", 64'({src_tready, busy}), 64'(0));
        check("async_rst_counters", 64'({frame_count, last_len}), 64'(0));
        bp_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        skip = 32'd2;
        expect_beat(32'd3, 1'b0, 1'b1);
        expect_beat(32'd4, 1'b1, 1'b0);
        send(32'h0002_0001, 1'b0);
        send(32'h0004_0003, 1'b1);
        wait_idle();
        check("post_rst_count", 64'(frame_count), 64'(1));
        check("post_rst_len", 64'(last_len), 64'(2));

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axis_sample_unpacker.md
# axis_sample_unpacker

Stream stage directly downstream of the FIFO interconnect's sink AXI Stream. Accepts 32-bit words, each carrying two packed signed 16-bit raw signal samples, and emits one sign-extended sample per beat toward the DTW core. Drops a programmable number of leading samples per frame (read-prefix trimming). Reports per-frame statistics to the register block.

## Interface
- AXIS_DATA_WIDTH, 32, input word width; must be 2*SAMPLE_WIDTH
- SAMPLE_WIDTH, 16, packed sample width
- OUT_WIDTH, 32, output sample width; sign-extended from SAMPLE_WIDTH
- CNT_WIDTH, 32, width of skip length and statistics counters
- AXIS_clk  in  1  single clock for all logic
- AXIS_rst  in  1  reset, asynchronous, active-low
- SRC_AXIS_tvalid  in  1  input word valid
- SRC_AXIS_tready  out  1  input word accepted when high with tvalid
- SRC_AXIS_tdata  in  AXIS_DATA_WIDTH  [15:0] first sample, [31:16] second sample
- SRC_AXIS_tlast  in  1  last word of frame
- SRC_AXIS_tuser  in  1  ignored
- SINK_AXIS_tvalid  out  1  output sample valid
- SINK_AXIS_tready  in  1  downstream accepts
- SINK_AXIS_tdata  out  OUT_WIDTH  sign-extended sample
- SINK_AXIS_tlast  out  1  last emitted sample of frame
- SINK_AXIS_tuser  out  1  first emitted sample of frame
- i_skip_len  in  CNT_WIDTH  leading samples to drop per frame
- o_frame_count  out  CNT_WIDTH  frames completed since reset (wraps)
- o_last_frame_len  out  CNT_WIDTH  samples emitted in most recent completed frame
- o_busy  out  1  high when a word is held or a frame is in progress

## Operation
- Holding register: word, tlast flag. FSM states: EMPTY, LO (low half pending), HI (high half pending).
- EMPTY: SRC_AXIS_tready=1. On accept -> LO. If no frame in progress (in_frame=0), latch skip_rem<=i_skip_len, set in_frame, clear out_cnt, set first_pending.
- LO: if skip_rem!=0, drop low sample, skip_rem-=1, -> HI next cycle, no output. Else SINK_AXIS_tvalid=1 with low sample, tlast=0; on tready -> HI.
- HI: if skip_rem!=0, drop high sample, skip_rem-=1. Else present high sample, tlast=held tlast flag.
- HI exit (drop, or output handshake): if held tlast, frame ends: o_frame_count+=1, o_last_frame_len<=out_cnt (+1 if this sample emitted), in_frame<=0. In same cycle SRC_AXIS_tready=1: if new word accepted -> LO, else -> EMPTY.
- SINK_AXIS_tuser=first_pending on every emitted beat; cleared on first output handshake of frame.
- out_cnt increments per output handshake; saturates at all-ones.
- Sign extension: tdata = {{(OUT_WIDTH-SAMPLE_WIDTH){s[15]}}, s}.
- All-skipped frame (skip >= 2*words): no output beats, no tlast emitted; o_frame_count still increments, o_last_frame_len=0.
- i_skip_len changes mid-frame have no effect until next frame start.

## Timing
- Reset (async assert, sync release): state EMPTY, SRC_AXIS_tready=0 during reset then 1 first cycle after release, SINK_AXIS_tvalid=0, tlast=0, tuser=0, tdata=0, counters 0, in_frame=0, o_busy=0.
- Latency: word accepted at cycle N -> low sample valid at N+1, high at N+2 (with tready high).
- Sustained throughput: 1 sample/cycle, 1 word per 2 cycles; no bubble between words.
- Each dropped sample costs one cycle.
- SINK_AXIS_tvalid/tdata/tlast/tuser registered; stable while tvalid=1 and tready=0.
- SRC_AXIS_tready combinational from state and SINK_AXIS_tready (HI case only); no tready->tready loop exists with the FIFO adapter.
- Reset mid-frame: held word and partial frame discarded; no statistics update.

## Structure
- Shared package: FSM state encoding (EMPTY/LO/HI), SAMPLE_WIDTH default, sign-extension function.
- Single module; no sub-module needed. Instantiated in the fifo interconnect top between the FIFO-to-AXIS adapter and the DTW core input; i_skip_len from a new control register.

## Test plan
- Skip 0, one word 0xFFFE_0003 with tlast, tready=1 -> beats 0x00000003 (tuser=1), 0xFFFFFFFE (tlast=1); frame_count=1, last_frame_len=2.
- Skip 3, frame of 3 words 0x0002_0001,0x0004_0003,0x0006_0005 -> outputs 4,5,6 only; tuser on 4, tlast on 6; last_frame_len=3.
- Skip 10, 2-word frame -> no output beats; frame_count increments, last_frame_len=0; next frame with skip 0 outputs normally with tuser on its first sample.
- Continuous 64-word frame, tready=1 -> 128 consecutive beats, no gaps, SRC_AXIS_tready pattern 1-0 alternating.
- Random tready backpressure (50%) -> output sequence identical to no-backpressure run; tdata held stable while stalled.
- Assert AXIS_rst low asynchronously mid-frame -> outputs return to reset values immediately; following frame starts clean with correct skip and tuser.
